// File: rtl/led_cnt_multi.sv
// led_cnt_multi: NUM_CH independent LED channels, each OFF / ON / BLINK / ONESHOT.
// Ports: clk100, rst (async, active-high), cfg_valid/cfg_ready write handshake,
//   cfg_ch/cfg_mode/cfg_period write payload, cfg_err invalid-channel pulse,
//   leds_o LED drive, done_o ONESHOT completion pulses, version constant.
// Build option: define LED_CNT_ONESHOT_EN to include ONESHOT mode and done_o.
module led_cnt_multi #(
    parameter int          NUM_CH     = 2,
    parameter int          CNT_W      = 27,
    parameter int          PERIOD_RST = 50_000_000,
    parameter logic [31:0] VERSION    = 32'hAAAA_0700,
    localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] leds_o,
    output logic [NUM_CH-1:0] done_o,
    output logic [31:0]       version
);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_ONE   = 2'd3;

    localparam logic [31:0]      NUM_CH_U = NUM_CH;
    localparam logic [CNT_W-1:0] PER_RST  = CNT_W'(PERIOD_RST);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [1:0]       mode_q   [NUM_CH];
    logic [1:0]       mode_d   [NUM_CH];
    logic [CNT_W-1:0] period_q [NUM_CH];
    logic [CNT_W-1:0] period_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_d    [NUM_CH];
    logic [CNT_W-1:0] per_eff  [NUM_CH];
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] wr, last;
    logic             rdy_q, rdy_d;
    logic             err_q, err_d;
    logic             acc, ch_ok;
    logic [1:0]       ld_mode;
    logic             ld_led;
`ifdef LED_CNT_ONESHOT_EN
    logic [NUM_CH-1:0] done_q, done_d;
`endif

    assign version   = VERSION;
    assign leds_o    = led_q;
    assign cfg_ready = rdy_q;
    assign cfg_err   = err_q;
`ifdef LED_CNT_ONESHOT_EN
    assign done_o    = done_q;
`else
    assign done_o    = '0;
`endif

    always_comb begin
        acc   = cfg_valid && rdy_q;
        ch_ok = {{(32-CH_W){1'b0}}, cfg_ch} < NUM_CH_U;
        // ready drops for exactly the cycle after an accept
        rdy_d = !acc;
        err_d = acc && !ch_ok;

        ld_mode = cfg_mode;
`ifndef LED_CNT_ONESHOT_EN
        if (cfg_mode == M_ONE) begin
            ld_mode = M_OFF;
        end
`endif
        ld_led = (ld_mode == M_ON) || (ld_mode == M_ONE);

        led_d = led_q;
`ifdef LED_CNT_ONESHOT_EN
        done_d = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            wr[i]       = acc && ch_ok && (cfg_ch == CH_W'(i));
            // period 0 behaves as period 1
            per_eff[i]  = (period_q[i] == '0) ? ONE : period_q[i];
            last[i]     = (cnt_q[i] == per_eff[i] - ONE);

            if (wr[i]) begin
                // a write overrides any same-cycle wrap or completion
                mode_d[i]   = ld_mode;
                period_d[i] = cfg_period;
                cnt_d[i]    = '0;
                led_d[i]    = ld_led;
            end else begin
                case (mode_q[i])
                    M_ON: begin
                        led_d[i] = 1'b1;
                        cnt_d[i] = '0;
                    end
                    M_BLINK: begin
                        if (last[i]) begin
                            cnt_d[i] = '0;
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + ONE;
                        end
                    end
`ifdef LED_CNT_ONESHOT_EN
                    M_ONE: begin
                        if (last[i]) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = 1'b0;
                            mode_d[i] = M_OFF;
                            done_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + ONE;
                            led_d[i] = 1'b1;
                        end
                    end
`endif
                    default: begin
                        led_d[i] = 1'b0;
                        cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            led_q <= '0;
`ifdef LED_CNT_ONESHOT_EN
            done_q <= '0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= M_BLINK;
                period_q[i] <= PER_RST;
                cnt_q[i]    <= '0;
            end
        end else begin
            rdy_q <= rdy_d;
            err_q <= err_d;
            led_q <= led_d;
`ifdef LED_CNT_ONESHOT_EN
            done_q <= done_d;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_cnt_multi.sv
// tb_led_cnt_multi: directed + random checks of led_cnt_multi against a
// time-since-load reference model (NUM_CH=3, CNT_W=8, PERIOD_RST=4).
module tb_led_cnt_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int PR  = 4;

    logic          clk100 = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [1:0]    cfg_mode;
    logic [CW-1:0] cfg_period;
    logic          cfg_err;
    logic [NCH-1:0] leds_o;
    logic [NCH-1:0] done_o;
    logic [31:0]   version;

    led_cnt_multi #(
        .NUM_CH(NCH), .CNT_W(CW), .PERIOD_RST(PR), .VERSION(32'hAAAA_0700)
    ) dut (
        .clk100(clk100), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_err(cfg_err), .leds_o(leds_o), .done_o(done_o),
        .version(version)
    );

    always #5 clk100 = ~clk100;

    int errors = 0;
    int checks = 0;

    // model: per channel mode, period, and edges elapsed since last load
    int m_mode [NCH];
    int m_per  [NCH];
    int m_t    [NCH];
    bit m_done [NCH];
    bit m_rdy;
    bit m_err;

    function automatic int eff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic logic [NCH-1:0] exp_leds();
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) begin
            case (m_mode[i])
                1: v[i] = 1'b1;
                2: v[i] = ((m_t[i] / eff(m_per[i])) % 2) == 1;
                3: v[i] = m_t[i] < eff(m_per[i]);
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_done();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_done[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 2;
            m_per[i]  = PR;
            m_t[i]    = 0;
            m_done[i] = 0;
        end
        m_rdy = 0;
        m_err = 0;
    endtask

    task automatic model_edge();
        bit acc;
        int md;
        acc = cfg_valid && m_rdy;
        md  = int'(cfg_mode);
`ifndef LED_CNT_ONESHOT_EN
        if (md == 3) md = 0;
`endif
        m_rdy = !acc;
        m_err = acc && (int'(cfg_ch) >= NCH);
        for (int i = 0; i < NCH; i++) begin
            m_done[i] = 0;
            if (acc && int'(cfg_ch) == i) begin
                m_mode[i] = md;
                m_per[i]  = int'(cfg_period);
                m_t[i]    = 0;
            end else begin
                m_t[i]++;
                if (m_mode[i] == 3 && m_t[i] == eff(m_per[i])) begin
                    m_done[i] = 1;
                    m_mode[i] = 0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NCH-1:0] el, ed;
        el = exp_leds();
        ed = exp_done();
        checks++;
        assert (leds_o === el) else begin
            errors++;
            $error("FAIL %s leds_o got=%b exp=%b", tag, leds_o, el);
        end
        checks++;
        assert (done_o === ed) else begin
            errors++;
            $error("FAIL %s done_o got=%b exp=%b", tag, done_o, ed);
        end
        checks++;
        assert (cfg_ready === m_rdy) else begin
            errors++;
            $error("FAIL %s cfg_ready got=%b exp=%b", tag, cfg_ready, m_rdy);
        end
        checks++;
        assert (cfg_err === m_err) else begin
            errors++;
            $error("FAIL %s cfg_err got=%b exp=%b", tag, cfg_err, m_err);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk100);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic write(input int ch, input int md, input int per,
                         input string tag);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_mode   = 2'(md);
        cfg_period = CW'(per);
        tick(tag);
        cfg_valid  = 1'b0;
        tick(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        #1;
        rst = 1'b0;
    endtask

    int acc_seen;
    int waited;

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = '0;
        cfg_period = '0;
        model_reset();
        #12;
        check_outputs("reset");
        rst = 1'b0;

        run(10, "free_blink");
        checks++;
        assert (version === 32'hAAAA_0700) else begin
            errors++;
            $error("FAIL version got=%h exp=%h", version, 32'hAAAA_0700);
        end

        write(1, 2, 2, "ch1_blink2");
        run(8, "ch1_run");

        write(2, 3, 5, "ch2_oneshot5");
        run(8, "ch2_run");

        write(3, 1, 0, "ch3_invalid");
        run(2, "after_invalid");
        write(0, 2, 0, "ch0_per0");
        run(4, "ch0_fast");

        // align an ON write with a ch0 wrap edge, then hold valid 4 cycles
        write(0, 2, 3, "ch0_blink3");
        waited = 0;
        while ((m_t[0] % 3) != 2 && waited < 10) begin
            tick("align");
            waited++;
        end
        checks++;
        assert (waited < 10) else begin
            errors++;
            $error("FAIL align_timeout waited=%0d exp<10", waited);
        end
        acc_seen   = 0;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd0;
        cfg_mode   = 2'd1;
        cfg_period = 8'd3;
        for (int k = 0; k < 4; k++) begin
            if (cfg_ready === 1'b1) acc_seen++;
            tick("hold_valid");
        end
        cfg_valid = 1'b0;
        checks++;
        assert (acc_seen === 2) else begin
            errors++;
            $error("FAIL accept_count got=%0d exp=%0d", acc_seen, 2);
        end
        run(3, "ch0_on");

        write(2, 3, 6, "ch2_oneshot6");
        run(2, "mid_oneshot");
        pulse_reset("rst_mid_oneshot");
        run(12, "post_reset");

        for (int k = 0; k < 500; k++) begin
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = CW'($urandom_range(0, 6));
            tick("random");
            if ($urandom_range(0, 99) == 0) pulse_reset("random_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_cnt_multi.md
LED_CNT_MULTI -- requirements
Module: led_cnt_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent LED channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 27, meaning the per-channel period counter width.
REQ-003 The block SHALL have parameter PERIOD_RST, default 50_000_000, meaning the reset period in clk100 cycles (0.5 s at 100 MHz).
REQ-004 The block SHALL have parameter VERSION, default 32'hAAAA_0700, meaning the constant driven on version.
REQ-005 Port clk100, input, 1 bit: the single clock; all logic is in this one clock domain.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port cfg_valid, input, 1 bit: the configuration write request.
REQ-008 Port cfg_ready, output, 1 bit: the block can accept a write this cycle.
REQ-009 Port cfg_ch, input, CH_W = max(1, clog2(NUM_CH)) bits: the target channel index.
REQ-010 Port cfg_mode, input, 2 bits: the mode encoding, 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT.
REQ-011 Port cfg_period, input, CNT_W bits: the period in cycles.
REQ-012 Port cfg_err, output, 1 bit: a one-cycle pulse flagging a write to an invalid channel.
REQ-013 Port leds_o, output, NUM_CH bits: the LED drive, bit i being channel i.
REQ-014 Port done_o, output, NUM_CH bits: a one-cycle pulse when channel i completes a ONESHOT.
REQ-015 Port version, output, 32 bits: constant, equal to VERSION.

Function
REQ-016 Each channel SHALL hold mode (2 b), period (CNT_W b), cnt (CNT_W b) and led (1 b) registers; leds_o[i] = led[i], registered with no combinational path from the inputs.
REQ-017 A write SHALL be accepted on any clk100 edge where cfg_valid and cfg_ready are both 1.
REQ-018 cfg_ready SHALL be 0 for exactly the one cycle after an accept and otherwise 1, limiting writes to at most one per 2 cycles; cfg_valid while cfg_ready = 0 SHALL be ignored, and the master holds its request.
REQ-019 Accept with cfg_ch < NUM_CH SHALL load that channel's mode and period, clear cnt to 0, and set led to OFF 0 / ON 1 / BLINK 0 / ONESHOT 1, all visible on the cycle after the accept.
REQ-020 Accept with cfg_ch >= NUM_CH SHALL change no channel state and SHALL drive cfg_err = 1 for exactly the next cycle.
REQ-021 An effective period of 0 SHALL be treated as 1.
REQ-022 In OFF the channel SHALL hold led = 0 and cnt = 0.
REQ-023 In ON the channel SHALL hold led = 1 and cnt = 0.
REQ-024 In BLINK, cnt SHALL increment every cycle; when cnt == period-1, cnt SHALL wrap to 0 and led SHALL toggle, giving a toggle every period cycles and a full LED cycle of 2*period.
REQ-025 In ONESHOT, led SHALL be 1 and cnt SHALL increment; when cnt == period-1, led SHALL go to 0, cnt to 0, mode to OFF, and done_o[i] SHALL pulse 1 for that one cycle, giving exactly period cycles of led = 1.
REQ-026 A write to a channel SHALL take priority over that channel's same-cycle wrap or ONESHOT completion; in that case no toggle and no done_o pulse SHALL occur.
REQ-027 Channels SHALL be fully independent, and a write to one channel SHALL NOT disturb any other channel's cnt or led.
REQ-028 cnt arithmetic SHALL be unsigned CNT_W-bit, and cnt SHALL never exceed period-1.

Reset
REQ-029 While rst = 1, asynchronously, every channel SHALL be in mode BLINK with period = PERIOD_RST, cnt = 0 and led = 0.
REQ-030 While rst = 1, the outputs SHALL be leds_o = 0, done_o = 0, cfg_err = 0 and cfg_ready = 0.
REQ-031 cfg_ready SHALL rise on the first clk100 edge after rst deasserts.
REQ-032 rst asserted mid-ONESHOT or mid-handshake SHALL abort it with no done_o and no cfg_err pulse.

Configuration
REQ-033 The macro LED_CNT_ONESHOT_EN SHALL compile the ONESHOT mode and done_o pulse generation in or out.
REQ-034 With LED_CNT_ONESHOT_EN defined, ONESHOT SHALL behave per REQ-025.
REQ-035 With LED_CNT_ONESHOT_EN undefined, cfg_mode = 3 SHALL be loaded as OFF and done_o SHALL be tied to 0; ports are unchanged in both builds.

Verification (bench: NUM_CH = 3, CNT_W = 8, PERIOD_RST = 4)
REQ-036 Release rst, no writes -> each leds_o bit toggles every 4 cycles (0000 1111 ...), all channels in phase, version = 32'hAAAA_0700.
REQ-037 Write ch1 BLINK period 2 -> cfg_ready low one cycle, leds_o[1] period 4 cycles, ch0/ch2 phase unchanged.
REQ-038 Write ch2 ONESHOT period 5 -> leds_o[2] = 1 for exactly 5 cycles, done_o[2] pulses once on the falling cycle, then stays 0; with the macro undefined -> leds_o[2] = 0, done_o = 0.
REQ-039 Write ch3 (invalid) ON -> cfg_err = 1 for one cycle, leds_o unchanged; write ch0 period 0 BLINK -> leds_o[0] toggles every cycle.
REQ-040 Write ch0 ON landing on ch0 wrap cycle, and cfg_valid held high 4 cycles -> leds_o[0] = 1 next cycle with no toggle glitch, and exactly 2 accepts.
REQ-041 Assert rst during a ONESHOT -> leds_o = 0 and done_o = 0 immediately; after release, BLINK period 4 resumes.
